// File: rtl/random_phase_injector_pkg.sv
// Shared types and constants for the per-node random phase injector and its LFSR.
package random_phase_injector_pkg;

    typedef logic [3:0] NL_out_phase_t;

    // One-hot so each state bit can be probed directly.
    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        ISSUE    = 4'b0010,
        HOLD     = 4'b0100,
        COOLDOWN = 4'b1000
    } inj_state_t;

    localparam logic [15:0] LFSR_RST_DEFAULT = 16'hACE1;
    // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;

endpackage

// File: rtl/phase_lfsr.sv
// 16-bit Galois LFSR that advances every cycle; a loaded zero seed is replaced by RST_VAL.
module phase_lfsr
    import random_phase_injector_pkg::*;
#(
    parameter logic [15:0] RST_VAL = LFSR_RST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        seed_load,
    output logic [15:0] lfsr_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_out <= RST_VAL;
        end else if (seed_load) begin
            lfsr_out <= (seed == 16'h0000) ? RST_VAL : seed;
        end else begin
            lfsr_out <= {1'b0, lfsr_out[15:1]} ^ (lfsr_out[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/random_phase_injector.sv
// Answers a stall flag with a pseudo-random phase kick: offer (valid/ready), hold, then cooldown.
module random_phase_injector
    import random_phase_injector_pkg::*;
#(
    parameter int          PHASE_W  = 4,
    parameter int          CNT_W    = 16,
    parameter logic [15:0] LFSR_RST = LFSR_RST_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inj_ena,
    input  logic             random_self_phase,
    input  NL_out_phase_t    nl_phase,
    input  logic [CNT_W-1:0] hold_T,
    input  logic [CNT_W-1:0] cooldown_T,
    input  logic [15:0]      seed,
    input  logic             seed_load,
    input  logic             inj_ready,
    output logic             inj_valid,
    output NL_out_phase_t    phase_out,
    output logic             inj_active,
    output logic             busy,
    output logic [CNT_W-1:0] inj_count,
    output inj_state_t       dbg_state,
    output logic [15:0]      dbg_lfsr
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Handshake: the kick transfers on any rising edge where inj_valid && inj_ready;
    // inj_valid stays high and the kick value stays stable until that edge.

    inj_state_t       state, state_nxt;
    NL_out_phase_t    rand_phase, rand_nxt, kick_cand, lfsr_low;
    logic [CNT_W-1:0] hold_cnt, hold_nxt, cool_cnt, cool_nxt;
    logic [15:0]      lfsr;
    logic             accept;

    phase_lfsr #(.RST_VAL(LFSR_RST)) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .seed      (seed),
        .seed_load (seed_load),
        .lfsr_out  (lfsr)
    );

    // A kick equal to the current phase would be invisible, so flip its LSB.
    assign lfsr_low  = lfsr[PHASE_W-1:0];
    assign kick_cand = (lfsr_low == nl_phase) ? {lfsr_low[PHASE_W-1:1], ~lfsr_low[0]} : lfsr_low;

    assign inj_valid  = (state == ISSUE);
    assign inj_active = (state == HOLD);
    assign busy       = (state != IDLE);
    assign accept     = inj_valid && inj_ready;
    assign dbg_state  = state;
    assign dbg_lfsr   = lfsr;

    always_comb begin
        state_nxt = state;
        rand_nxt  = rand_phase;
        hold_nxt  = hold_cnt;
        cool_nxt  = cool_cnt;
        if (!inj_ena) begin
            state_nxt = IDLE;
            hold_nxt  = '0;
            cool_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (random_self_phase) begin
                        rand_nxt  = kick_cand;
                        state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    if (inj_ready) begin
                        if (hold_T != '0) begin
                            hold_nxt  = hold_T;
                            state_nxt = HOLD;
                        end else begin
                            cool_nxt  = cooldown_T;
                            state_nxt = COOLDOWN;
                        end
                    end
                end
                HOLD: begin
                    hold_nxt = hold_cnt - CNT_ONE;
                    if (hold_cnt == CNT_ONE) begin
                        cool_nxt  = cooldown_T;
                        state_nxt = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    // A zero cooldown still spends one cycle here.
                    if (cool_cnt <= CNT_ONE) begin
                        cool_nxt  = '0;
                        state_nxt = IDLE;
                    end else begin
                        cool_nxt = cool_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                    cool_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rand_phase <= '0;
            hold_cnt   <= '0;
            cool_cnt   <= '0;
            phase_out  <= '0;
            inj_count  <= '0;
        end else begin
            state      <= state_nxt;
            rand_phase <= rand_nxt;
            hold_cnt   <= hold_nxt;
            cool_cnt   <= cool_nxt;
            phase_out  <= (state_nxt == HOLD) ? rand_nxt : nl_phase;
            if (accept && (inj_count != '1)) begin
                inj_count <= inj_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_random_phase_injector.sv
// Directed bench for random_phase_injector with a queue-based kick scoreboard.
module tb_random_phase_injector;
    import random_phase_injector_pkg::*;

    localparam int CNT_W = 16;
    localparam int W     = 4 + CNT_W;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             inj_ena, random_self_phase, seed_load, inj_ready;
    NL_out_phase_t    nl_phase;
    logic [CNT_W-1:0] hold_T, cooldown_T;
    logic [15:0]      seed;
    logic             inj_valid, inj_active, busy;
    NL_out_phase_t    phase_out;
    logic [CNT_W-1:0] inj_count;
    inj_state_t       dbg_state;
    logic [15:0]      dbg_lfsr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    random_phase_injector #(.PHASE_W(4), .CNT_W(CNT_W), .LFSR_RST(16'hACE1)) dut (
        .clk               (clk),
        .reset             (reset),
        .inj_ena           (inj_ena),
        .random_self_phase (random_self_phase),
        .nl_phase          (nl_phase),
        .hold_T            (hold_T),
        .cooldown_T        (cooldown_T),
        .seed              (seed),
        .seed_load         (seed_load),
        .inj_ready         (inj_ready),
        .inj_valid         (inj_valid),
        .phase_out         (phase_out),
        .inj_active        (inj_active),
        .busy              (busy),
        .inj_count         (inj_count),
        .dbg_state         (dbg_state),
        .dbg_lfsr          (dbg_lfsr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic arm(input logic [15:0] s);
        seed      = s;
        seed_load = 1'b1;
        tick();
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            tick();
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0]     e;
        NL_out_phase_t    cur_phase;
        logic [CNT_W-1:0] cur_hold;
        int               run_len;
        bit               in_hold;
        in_hold   = 1'b0;
        run_len   = 0;
        cur_phase = '0;
        cur_hold  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_hold = 1'b0;
            end else begin
                if (in_hold) begin
                    if (inj_active) begin
                        run_len++;
                        check("hold_phase", 32'(phase_out), 32'(cur_phase));
                    end else begin
                        check("hold_len", 32'(run_len), 32'(cur_hold));
                        in_hold = 1'b0;
                    end
                end
                if (inj_valid && inj_ready) begin
                    check("kick_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e         = exp_q.pop_front();
                        cur_phase = e[W-1:CNT_W];
                        cur_hold  = e[CNT_W-1:0];
                        run_len   = 0;
                        in_hold   = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int b, v, a, n, k;
        int kick_at[4];
        inj_ena           = 1'b1;
        random_self_phase = 1'b0;
        nl_phase          = 4'h0;
        hold_T            = 16'd3;
        cooldown_T        = 16'd2;
        seed              = 16'h0000;
        seed_load         = 1'b0;
        inj_ready         = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_phase_out", 32'(phase_out), 32'd0);
        check("rst_valid", 32'(inj_valid), 32'd0);
        check("rst_active", 32'(inj_active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(inj_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_lfsr", 32'(dbg_lfsr), 32'hACE1);
        reset = 1'b0;
        tick();

        // 1: 1-cycle pulse, hold 3, cooldown 2, ready already high
        nl_phase = 4'h3;
        arm(16'h000A);
        exp_q.push_back({4'hA, 16'd3});
        random_self_phase = 1'b1;
        tick();
        random_self_phase = 1'b0;
        seed_load = 1'b0;
        check("valid_after_request", 32'(inj_valid), 32'd1);
        check("issue_tracks_nl", 32'(phase_out), 32'h3);
        b = 0; v = 0; a = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) b++;
            if (inj_valid) v++;
            if (inj_active) a++;
            tick();
        end
        check("t1_busy_cycles", 32'(b), 32'd6);
        check("t1_valid_cycles", 32'(v), 32'd1);
        check("t1_active_cycles", 32'(a), 32'd3);
        check("t1_count", 32'(inj_count), 32'd1);

        // 2: ready low for 5 cycles while the LFSR keeps running
        hold_T = 16'd2; cooldown_T = 16'd1; nl_phase = 4'h3; inj_ready = 1'b0;
        arm(16'h00C6);
        exp_q.push_back({4'h6, 16'd2});
        random_self_phase = 1'b1;
        tick();
        random_self_phase = 1'b0;
        seed_load = 1'b0;
        v = 0;
        for (int i = 0; i < 5; i++) begin
            if (inj_valid) v++;
            if (i < 4) tick();
        end
        check("t2_valid_wait", 32'(v), 32'd5);
        check("t2_no_hold_early", 32'(inj_active), 32'd0);
        inj_ready = 1'b1;
        tick();
        check("t2_hold_on_ready", 32'(inj_active), 32'd1);
        wait_idle(n);
        check("t2_hold_cool_cycles", 32'(n), 32'd3);
        check("t2_count", 32'(inj_count), 32'd2);

        // 3: LFSR low bits equal nl_phase, zero cooldown
        hold_T = 16'd2; cooldown_T = 16'd0; nl_phase = 4'h5;
        arm(16'h1235);
        exp_q.push_back({4'h4, 16'd2});
        random_self_phase = 1'b1;
        tick();
        random_self_phase = 1'b0;
        seed_load = 1'b0;
        wait_idle(n);
        check("t3_busy_cycles", 32'(n), 32'd4);
        check("t3_count", 32'(inj_count), 32'd3);

        // 4: request held high, hold 1, cooldown 4 -> one kick every 7 cycles
        hold_T = 16'd1; cooldown_T = 16'd4; nl_phase = 4'h0;
        arm(16'h0009);
        repeat (3) exp_q.push_back({4'h9, 16'd1});
        random_self_phase = 1'b1;
        k = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (inj_valid && k < 4) begin
                kick_at[k] = i;
                k++;
            end
        end
        random_self_phase = 1'b0;
        seed_load = 1'b0;
        check("t4_kicks", 32'(k), 32'd3);
        check("t4_kick0", 32'(kick_at[0]), 32'd1);
        check("t4_kick1", 32'(kick_at[1]), 32'd8);
        check("t4_kick2", 32'(kick_at[2]), 32'd15);
        wait_idle(n);
        check("t4_count", 32'(inj_count), 32'd6);

        // 5a: drop inj_ena mid-HOLD
        hold_T = 16'd5; cooldown_T = 16'd2; nl_phase = 4'h2;
        arm(16'h0007);
        exp_q.push_back({4'h7, 16'd2});
        random_self_phase = 1'b1;
        tick();
        random_self_phase = 1'b0;
        seed_load = 1'b0;
        tick();
        tick();
        inj_ena = 1'b0;
        tick();
        check("t5_ena_busy", 32'(busy), 32'd0);
        check("t5_ena_active", 32'(inj_active), 32'd0);
        check("t5_ena_state", 32'(dbg_state), 32'(IDLE));
        check("t5_ena_phase", 32'(phase_out), 32'h2);
        nl_phase = 4'h9;
        tick();
        check("t5_ena_track", 32'(phase_out), 32'h9);
        check("t5_ena_count_kept", 32'(inj_count), 32'd7);
        inj_ena = 1'b1;

        // 5b: async reset while in ISSUE
        inj_ready = 1'b0;
        arm(16'h0004);
        random_self_phase = 1'b1;
        tick();
        random_self_phase = 1'b0;
        seed_load = 1'b0;
        check("t5_issue_valid", 32'(inj_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(inj_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_count", 32'(inj_count), 32'd0);
        check("t5_rst_phase", 32'(phase_out), 32'd0);
        check("t5_rst_lfsr", 32'(dbg_lfsr), 32'hACE1);
        tick();
        reset = 1'b0;
        inj_ready = 1'b1;
        tick();

        // 6: zero seed becomes ACE1, zero hold never asserts inj_active
        hold_T = 16'd0; cooldown_T = 16'd1; nl_phase = 4'h0;
        arm(16'h0000);
        check("t6_seed0_lfsr", 32'(dbg_lfsr), 32'hACE1);
        exp_q.push_back({4'h1, 16'd0});
        random_self_phase = 1'b1;
        tick();
        random_self_phase = 1'b0;
        seed_load = 1'b0;
        b = 0; a = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) b++;
            if (inj_active) a++;
            tick();
        end
        check("t6_active_cycles", 32'(a), 32'd0);
        check("t6_busy_cycles", 32'(b), 32'd2);

        // 6b: eight free-running steps from ACE1 exercise the taps
        arm(16'h0000);
        seed_load = 1'b0;
        repeat (8) tick();
        check("t6_lfsr_step8", 32'(dbg_lfsr), 32'hC2C4);
        hold_T = 16'd1; cooldown_T = 16'd0;
        exp_q.push_back({4'h4, 16'd1});
        random_self_phase = 1'b1;
        tick();
        random_self_phase = 1'b0;
        wait_idle(n);
        repeat (2) tick();
        check("final_count", 32'(inj_count), 32'd2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
